// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: fetches 32-bit words, queues 16-bit parcels and presents
// compressed/32-bit instructions. Define FETCH_PERF_CNT_EN to add the decoder stall counter.
module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        inst_compressed,
  output logic [31:0] inst_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FILL_LIMIT  = CNT_W'(DEPTH - 2);
  localparam logic [31:0]      RESET_FETCH = {RESET_ADDR[31:2], 2'b00};

  logic [15:0]      buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic             half_q, half_d;
  logic [31:0]      inst_addr_q, inst_addr_d;
  logic             outstanding_q, outstanding_d;
  logic             discard_q, discard_d;
  logic             req_valid_q, req_valid_d;
  logic [31:0]      req_addr_q, req_addr_d;

  logic [15:0] head_lo;
  logic [15:0] head_hi;
  logic        head_rvc;
  logic        avail;
  logic        pop;
  logic        push;
  logic        rsp_take;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic        unused_redirect_bit0;

  assign unused_redirect_bit0 = redirect_addr[0];

  // Head decode feeds the decoder with no register stage
  assign head_lo         = buf_q[rd_ptr_q];
  assign head_hi         = buf_q[rd_ptr_q + PTR_W'(1)];
  assign head_rvc        = (head_lo[1:0] != 2'b11);
  assign avail           = head_rvc ? (count_q >= CNT_W'(1)) : (count_q >= CNT_W'(2));
  assign inst_valid      = !rst && avail;
  assign inst_compressed = head_rvc;
  assign inst_data       = rst ? 32'h0 : (head_rvc ? {16'h0, head_lo} : {head_hi, head_lo});
  assign inst_addr       = inst_addr_q;
  assign mem_req_valid   = !rst && req_valid_q;
  assign mem_req_addr    = rst ? RESET_FETCH : req_addr_q;

  assign pop      = avail && inst_ready && !redirect_valid;
  assign pop_n    = !pop ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
  assign rsp_take = outstanding_q && mem_rsp_valid;
  assign push     = rsp_take && !discard_q && !redirect_valid;
  assign push_n   = !push ? 2'd0 : (half_q ? 2'd1 : 2'd2);

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push_n);
    count_d       = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    inst_addr_d   = inst_addr_q + {29'd0, pop_n, 1'b0};
    fetch_addr_d  = fetch_addr_q;
    half_d        = half_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;

    if (push) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
      half_d       = 1'b0;
    end
    if (rsp_take) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (req_valid_q && mem_req_ready) begin
      req_valid_d   = 1'b0;
      outstanding_d = 1'b1;
    end

    // A flush lets any in-flight request finish but marks its data as stale
    if (redirect_valid) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = {redirect_addr[31:2], 2'b00};
      half_d       = redirect_addr[1];
      inst_addr_d  = {redirect_addr[31:2], redirect_addr[1], 1'b0};
      discard_d    = outstanding_d || req_valid_d;
    end

    if (!req_valid_d && !outstanding_d && (count_d <= FILL_LIMIT)) begin
      req_valid_d = 1'b1;
      req_addr_d  = fetch_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_addr_q  <= RESET_FETCH;
      half_q        <= RESET_ADDR[1];
      inst_addr_q   <= RESET_ADDR;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_FETCH;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      half_q        <= half_d;
      inst_addr_q   <= inst_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
    end
  end

  // Parcel storage; a halfword-entry response only carries its upper parcel
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (half_q) begin
        buf_q[wr_ptr_q] <= mem_rsp_data[31:16];
      end else begin
        buf_q[wr_ptr_q]               <= mem_rsp_data[15:0];
        buf_q[wr_ptr_q + PTR_W'(1)]   <= mem_rsp_data[31:16];
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Cycles where the decoder was ready but no instruction was available
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if (inst_ready && !avail && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Self-checking bench for instruction_prefetch_buffer: DEPTH=8 and DEPTH=4 instances,
// tb memory model with response latency control, scoreboard of expected instructions.
module tb_instruction_prefetch_buffer;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        comp;
  } exp_t;

  logic        clk;
  logic        rst, mem_req_valid, mem_req_ready, mem_rsp_valid, redirect_valid;
  logic        inst_valid, inst_ready, inst_compressed;
  logic [31:0] mem_req_addr, mem_rsp_data, redirect_addr, inst_data, inst_addr;
  logic        rst4, mem_req_valid4, mem_req_ready4, mem_rsp_valid4, redirect_valid4;
  logic        inst_valid4, inst_ready4, inst_compressed4;
  logic [31:0] mem_req_addr4, mem_rsp_data4, redirect_addr4, inst_data4, inst_addr4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_stall_cycles4;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] prog [256];
  logic        auto_ready, pend, out_tb;
  logic [31:0] pend_addr;
  int          pend_wait, rsp_delay, acc4_cnt, pops4;

  instruction_prefetch_buffer #(.DEPTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_compressed(inst_compressed), .inst_addr(inst_addr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  instruction_prefetch_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .mem_req_valid(mem_req_valid4), .mem_req_addr(mem_req_addr4), .mem_req_ready(mem_req_ready4),
    .mem_rsp_valid(mem_rsp_valid4), .mem_rsp_data(mem_rsp_data4),
    .redirect_valid(redirect_valid4), .redirect_addr(redirect_addr4),
    .inst_valid(inst_valid4), .inst_ready(inst_ready4), .inst_data(inst_data4),
    .inst_compressed(inst_compressed4), .inst_addr(inst_addr4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] a, input logic c);
    exp_t e;
    e.data = d;
    e.addr = a;
    e.comp = c;
    return e;
  endfunction

  // One clock: consume/compare at the current outputs, then model memory after the edge
  task automatic tick();
    logic        acc, acc4, rsp_now;
    logic [31:0] acc_addr, acc_addr4;
    exp_t        e;
    if (auto_ready) inst_ready = (exp_q.size() != 0);
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst_addr", inst_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("inst_data", inst_data, e.data);
        check("inst_addr", inst_addr, e.addr);
        check("inst_comp", 32'(inst_compressed), 32'(e.comp));
      end
    end
    if (inst_valid4 && inst_ready4) begin
      pops4++;
      if (exp4_q.size() == 0) begin
        check("d4_unexpected_inst_addr", inst_addr4, 32'hFFFF_FFFF);
      end else begin
        e = exp4_q.pop_front();
        check("d4_inst_data", inst_data4, e.data);
        check("d4_inst_addr", inst_addr4, e.addr);
      end
    end
    acc      = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    rsp_now  = mem_rsp_valid;
    if (acc) begin
      check("one_outstanding", 32'(out_tb), 32'd0);
      acc_q.push_back(acc_addr);
    end
    acc4      = mem_req_valid4 && mem_req_ready4;
    acc_addr4 = mem_req_addr4;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rsp_now) out_tb = 1'b0;
    if (acc) begin
      out_tb    = 1'b1;
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_wait = rsp_delay;
    end
    mem_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = prog[pend_addr[9:2]];
        pend          = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    mem_rsp_valid4 = acc4;
    if (acc4) begin
      acc4_cnt++;
      mem_rsp_data4 = {acc_addr4[15:0] + 16'd2, acc_addr4[15:0]};
      exp4_q.push_back(mk({16'h0, acc_addr4[15:0]}, acc_addr4, 1'b1));
      exp4_q.push_back(mk({16'h0, acc_addr4[15:0] + 16'd2}, acc_addr4 + 32'd2, 1'b1));
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    auto_ready = 1'b0;
    inst_ready = 1'b0;
    pend       = 1'b0;
    out_tb     = 1'b0;
    rsp_delay  = 0;
    exp_q.delete();
    repeat (2) tick();
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    rst        = 1'b0;
    auto_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    rst4 = 1'b1; mem_req_ready4 = 1'b1; mem_rsp_valid4 = 1'b0; mem_rsp_data4 = '0;
    redirect_valid4 = 1'b0; redirect_addr4 = '0; inst_ready4 = 1'b0;
    auto_ready = 1'b0; pend = 1'b0; out_tb = 1'b0; pend_addr = '0; pend_wait = 0;
    rsp_delay = 0; acc4_cnt = 0; pops4 = 0;
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;

    // Two compressed parcels in one word
    prog[0] = 32'h4501_0001;
    do_reset();
    exp_q.push_back(mk(32'h0000_0001, 32'h0, 1'b1));
    exp_q.push_back(mk(32'h0000_4501, 32'h2, 1'b1));
    drain("t1_drain", 30);

    // Two full-width instructions
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0000_0093;
    do_reset();
    exp_q.push_back(mk(32'h0000_0013, 32'h0, 1'b0));
    exp_q.push_back(mk(32'h0000_0093, 32'h4, 1'b0));
    drain("t2_drain", 30);

    // Redirect-to-valid latency at zero wait
    repeat (20) tick();
    prog[8] = 32'h0000_0002;
    exp_q.push_back(mk(32'h0000_0002, 32'h20, 1'b1));
    redirect_to(32'h20);
    check("lat_req_valid", 32'(mem_req_valid), 32'd1);
    check("lat_req_addr", mem_req_addr, 32'h20);
    tick();
    check("lat_rsp_cycle_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("lat_inst_valid", 32'(inst_valid), 32'd1);
    check("lat_inst_addr", inst_addr, 32'h20);
    drain("t5_drain", 10);

    // Redirect to 0x102 while the 0x100 request is outstanding
    repeat (20) tick();
    prog[8'h40] = 32'hAAAA_BBBB;
    prog[8'h41] = 32'h0000_0001;
    acc_q.delete();
    rsp_delay = 4;
    redirect_to(32'h100);
    check("t3_req_addr", mem_req_addr, 32'h100);
    tick();
    exp_q.push_back(mk(32'h0000_AAAA, 32'h102, 1'b1));
    exp_q.push_back(mk(32'h0000_0001, 32'h104, 1'b1));
    redirect_to(32'h102);
    rsp_delay = 0;
    drain("t3_drain", 40);
    check("t3_acc0", acc_q[0], 32'h100);
    check("t3_acc1", acc_q[1], 32'h100);

    // Redirect while a request is held unaccepted
    repeat (20) tick();
    prog[8'h10] = 32'hFFFF_FFFF;
    prog[8'h20] = 32'h0000_0005;
    acc_q.delete();
    mem_req_ready = 1'b0;
    redirect_to(32'h40);
    repeat (2) tick();
    check("hold_valid", 32'(mem_req_valid), 32'd1);
    check("hold_addr", mem_req_addr, 32'h40);
    exp_q.push_back(mk(32'h0000_0005, 32'h80, 1'b1));
    redirect_to(32'h80);
    check("hold_addr_after_redirect", mem_req_addr, 32'h40);
    mem_req_ready = 1'b1;
    drain("t6_drain", 40);
    check("t6_acc0", acc_q[0], 32'h40);
    check("t6_acc1", acc_q[1], 32'h80);

    // Full-width instruction split across two words
    repeat (20) tick();
    prog[1] = 32'h5677_0000;
    prog[2] = 32'h0000_1234;
    exp_q.push_back(mk(32'h1234_5677, 32'h6, 1'b0));
    redirect_to(32'h6);
    check("split_req_addr", mem_req_addr, 32'h4);
    repeat (2) tick();
    check("split_half_inst_valid", 32'(inst_valid), 32'd0);
    repeat (2) tick();
    check("split_inst_valid", 32'(inst_valid), 32'd1);
    check("split_inst_addr", inst_addr, 32'h6);
    drain("t4_drain", 10);

    // Redirect wins over a concurrent instruction handshake
    repeat (20) tick();
    prog[8'h80] = 32'h0000_0009;
    auto_ready = 1'b0;
    inst_ready = 1'b1;
    redirect_to(32'h200);
    inst_ready = 1'b0;
    check("redir_hs_inst_addr", inst_addr, 32'h200);
    check("redir_hs_inst_valid", 32'(inst_valid), 32'd0);
    auto_ready = 1'b1;
    exp_q.push_back(mk(32'h0000_0009, 32'h200, 1'b1));
    drain("t7_drain", 10);

`ifdef FETCH_PERF_CNT_EN
    rst4 = 1'b1; inst_ready4 = 1'b0; mem_req_ready4 = 1'b0;
    repeat (2) tick();
    rst4 = 1'b0; inst_ready4 = 1'b1;
    repeat (5) tick();
    inst_ready4 = 1'b0;
    check("perf_stall_cycles", perf_stall_cycles4, 32'd5);
`endif

    // DEPTH=4: backpressure caps fetches, then drain across pointer wrap
    rst4 = 1'b1; inst_ready4 = 1'b0; mem_req_ready4 = 1'b1;
    repeat (2) tick();
    exp4_q.delete();
    acc4_cnt = 0;
    rst4 = 1'b0;
    repeat (20) tick();
    check("d4_accepts", 32'(acc4_cnt), 32'd2);
    check("d4_no_third_req", 32'(mem_req_valid4), 32'd0);
    check("d4_inst_valid", 32'(inst_valid4), 32'd1);
    pops4 = 0;
    inst_ready4 = 1'b1;
    repeat (30) tick();
    inst_ready4 = 1'b0;
    check("d4_pops_ge8", 32'(pops4 >= 8), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
